// File: rtl/t07_simon_sequence_display.sv
// Simon Says playback driver: flashes colours 0..stage of the live colour bus while the
// press detector sits in a display state, then pauses and repeats; all LEDs lit on an error.
module t07_simon_sequence_display #(
  parameter int CNT_W      = 24,
  parameter int ON_CYCLES  = 6_000_000,
  parameter int OFF_CYCLES = 3_000_000,
  parameter int GAP_CYCLES = 12_000_000,
  parameter int ERR_CYCLES = 6_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] playing_state_in,
  input  logic       activate_rand,
  input  logic [3:0] simon_state_in,
  input  logic [9:0] simon_sequence_bus,
  input  logic       simon_error,
  output logic [3:0] simon_led,
  output logic [1:0] color_out,
  output logic       color_valid,
  output logic       seq_done,
  output logic       busy
);

  typedef enum logic [2:0] {IDLE, ON, OFF, GAP, ERR} phase_t;

  localparam logic [CNT_W-1:0] ON_LAST  = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] OFF_LAST = CNT_W'(OFF_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ERR_LAST = CNT_W'(ERR_CYCLES - 1);
  localparam logic             ON_ONE   = (ON_CYCLES == 1);

  phase_t           phase;
  logic [2:0]       idx;
  logic [CNT_W-1:0] cnt;
  logic [3:0]       state_q;

  logic       active;
  logic [2:0] stage;
  logic [1:0] col_idx;
  logic [1:0] col_zero;
  logic [1:0] col_next;

  function automatic logic [1:0] colour(input logic [9:0] bus, input logic [2:0] i);
    logic [1:0] c;
    case (i)
      3'd0:    c = bus[1:0];
      3'd1:    c = bus[3:2];
      3'd2:    c = bus[5:4];
      3'd3:    c = bus[7:6];
      default: c = bus[9:8];
    endcase
    return c;
  endfunction

  assign active   = (playing_state_in == 3'd4) && !simon_state_in[0] && (simon_state_in <= 4'd8);
  assign stage    = simon_state_in[3:1];
  assign col_idx  = colour(simon_sequence_bus, idx);
  assign col_zero = colour(simon_sequence_bus, 3'd0);
  assign col_next = colour(simon_sequence_bus, idx + 3'd1);

  always_ff @(posedge clk) begin
    seq_done <= 1'b0;
    if (rst || activate_rand) begin
      phase       <= IDLE;
      idx         <= 3'd0;
      cnt         <= '0;
      state_q     <= 4'd0;
      simon_led   <= 4'b0000;
      color_out   <= 2'd0;
      color_valid <= 1'b0;
      busy        <= 1'b0;
    end else if (simon_error) begin
      phase       <= ERR;
      cnt         <= '0;
      idx         <= 3'd0;
      simon_led   <= 4'b1111;
      color_out   <= 2'd0;
      color_valid <= 1'b0;
      busy        <= 1'b1;
    end else if (phase == ERR) begin
      if (cnt == ERR_LAST) begin
        phase     <= IDLE;
        cnt       <= '0;
        simon_led <= 4'b0000;
        busy      <= 1'b0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end else if (phase != IDLE && !active) begin
      phase       <= IDLE;
      idx         <= 3'd0;
      cnt         <= '0;
      simon_led   <= 4'b0000;
      color_out   <= 2'd0;
      color_valid <= 1'b0;
      busy        <= 1'b0;
    end else if ((phase == IDLE && active) || (phase != IDLE && simon_state_in != state_q)) begin
      // fresh playback from colour 0: first entry, or the detector moved to another stage
      phase       <= ON;
      idx         <= 3'd0;
      cnt         <= '0;
      state_q     <= simon_state_in;
      simon_led   <= 4'b0001 << col_zero;
      color_out   <= col_zero;
      color_valid <= 1'b1;
      busy        <= 1'b1;
      seq_done    <= ON_ONE && (stage == 3'd0);
    end else begin
      case (phase)
        ON: begin
          if (cnt == ON_LAST) begin
            phase       <= (idx == stage) ? GAP : OFF;
            idx         <= (idx == stage) ? idx : idx + 3'd1;
            cnt         <= '0;
            simon_led   <= 4'b0000;
            color_out   <= 2'd0;
            color_valid <= 1'b0;
          end else begin
            // seq_done coincides with the final lit cycle of the last colour
            cnt       <= cnt + 1'b1;
            simon_led <= 4'b0001 << col_idx;
            color_out <= col_idx;
            seq_done  <= ((cnt + 1'b1) == ON_LAST) && (idx == stage);
          end
        end
        OFF: begin
          if (cnt == OFF_LAST) begin
            phase       <= ON;
            cnt         <= '0;
            simon_led   <= 4'b0001 << col_idx;
            color_out   <= col_idx;
            color_valid <= 1'b1;
            seq_done    <= ON_ONE && (idx == stage);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            phase       <= ON;
            idx         <= 3'd0;
            cnt         <= '0;
            simon_led   <= 4'b0001 << col_zero;
            color_out   <= col_zero;
            color_valid <= 1'b1;
            seq_done    <= ON_ONE && (stage == 3'd0);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          cnt <= '0;
        end
      endcase
    end
  end

  logic unused_next;
  assign unused_next = ^col_next;

endmodule

// File: tb/tb_t07_simon_sequence_display.sv
// Scoreboard bench for the Simon playback driver: stimulus queues expected per-cycle outputs,
// a monitor pops and compares one entry after every clock edge.
module tb_t07_simon_sequence_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [2:0] playing_state_in = 3'd0;
  logic       activate_rand = 1'b0;
  logic [3:0] simon_state_in = 4'd0;
  logic [9:0] simon_sequence_bus = 10'b00_01_10_11_00;
  logic       simon_error = 1'b0;
  logic [3:0] simon_led;
  logic [1:0] color_out;
  logic       color_valid;
  logic       seq_done;
  logic       busy;

  t07_simon_sequence_display #(
    .CNT_W(8), .ON_CYCLES(4), .OFF_CYCLES(2), .GAP_CYCLES(8), .ERR_CYCLES(3)
  ) dut (
    .clk(clk), .rst(rst), .playing_state_in(playing_state_in), .activate_rand(activate_rand),
    .simon_state_in(simon_state_in), .simon_sequence_bus(simon_sequence_bus),
    .simon_error(simon_error), .simon_led(simon_led), .color_out(color_out),
    .color_valid(color_valid), .seq_done(seq_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [8:0] v;
    string      name;
  } exp_t;

  exp_t exp_q[$];
  int   passed = 0;
  int   total  = 0;
  bit   done   = 1'b0;

  // monitor: one expected entry per edge, packed as {led, colour, valid, done, busy}
  initial begin
    exp_t e;
    logic [8:0] act;
    while (!done) begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e   = exp_q.pop_front();
        act = {simon_led, color_out, color_valid, seq_done, busy};
        total++;
        if (act === e.v) passed++;
        else $display("FAIL %s: got led/col/val/done/busy=%b required %b at %0t", e.name, act, e.v, $time);
      end
    end
  end

  string tag = "reset";

  task automatic exp1(input logic [3:0] led, input logic [1:0] c, input logic v, input logic d,
                      input logic b);
    exp_t e;
    e.v    = {led, c, v, d, b};
    e.name = tag;
    exp_q.push_back(e);
    @(negedge clk);
  endtask

  task automatic on_run(input logic [1:0] c, input logic last);
    for (int i = 0; i < 4; i++) exp1(4'b0001 << c, c, 1'b1, last && (i == 3), 1'b1);
  endtask

  task automatic dark(input int n);
    for (int i = 0; i < n; i++) exp1(4'b0000, 2'd0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) exp1(4'b0000, 2'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic err(input int n);
    for (int i = 0; i < n; i++) exp1(4'b1111, 2'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    @(negedge clk);
    idle(1);
    rst = 1'b0;

    // colours: c0=0 c1=3 c2=2 c3=1 c4=0
    tag = "t1_d3";
    playing_state_in = 3'd4;
    simon_state_in   = 4'd4;
    on_run(2'd0, 1'b0); dark(2);
    on_run(2'd3, 1'b0); dark(2);
    on_run(2'd2, 1'b1); dark(8);
    on_run(2'd0, 1'b0);

    tag = "t2_d1";
    simon_state_in = 4'd0;
    on_run(2'd0, 1'b1); dark(8);
    on_run(2'd0, 1'b1);

    tag = "t3_error";
    simon_state_in = 4'd4;
    on_run(2'd0, 1'b0); dark(2);
    exp1(4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);
    exp1(4'b1000, 2'd3, 1'b1, 1'b0, 1'b1);
    simon_error = 1'b1;
    err(1);
    simon_error = 1'b0;
    err(2);
    idle(1);
    on_run(2'd0, 1'b0);

    tag = "t4_leave";
    dark(1);
    simon_state_in = 4'd5;
    idle(3);
    tag = "t4_d4";
    simon_state_in = 4'd6;
    on_run(2'd0, 1'b0); dark(2);
    on_run(2'd3, 1'b0); dark(2);
    on_run(2'd2, 1'b0); dark(2);
    on_run(2'd1, 1'b1); dark(8);

    tag = "t5_rst";
    exp1(4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
    exp1(4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    tag = "t5_not_simon";
    playing_state_in = 3'd3;
    simon_state_in   = 4'd0;
    idle(3);

    tag = "t6_act_in_err";
    playing_state_in = 3'd4;
    exp1(4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
    simon_error = 1'b1;
    err(1);
    simon_error = 1'b0;
    err(1);
    activate_rand = 1'b1;
    idle(1);
    activate_rand = 1'b0;
    exp1(4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);
    tag = "t6_both";
    simon_error   = 1'b1;
    activate_rand = 1'b1;
    idle(1);
    simon_error   = 1'b0;
    activate_rand = 1'b0;
    exp1(4'b0001, 2'd0, 1'b1, 1'b0, 1'b1);

    @(negedge clk);
    done = 1'b1;
    total++;
    if (exp_q.size() == 0) passed++;
    else $display("FAIL drain: got %0d queued entries required 0", exp_q.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
